// File: rtl/conway_pkg.sv
// Shared definitions for the conway board: default geometry and sequencer states.
package conway_pkg;

  localparam int DEF_ROWS = 8;
  localparam int DEF_COLS = 8;

  typedef enum logic [1:0] {
    S_LOAD,
    S_LATCH,
    S_HALT,
    S_RUN
  } seq_state_t;

endpackage

// File: rtl/conway_sequencer_tick_divider.sv
// Generation prescaler: down-counter that fires once every TICKS enabled cycles.
module tick_divider #(
  parameter int TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(TICKS - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == '0);

  // Count down while enabled; reload on terminal count or clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= RELOAD;
    end else if (clear) begin
      cnt <= RELOAD;
    end else if (en) begin
      cnt <= (cnt == '0) ? RELOAD : cnt - 1'b1;
    end
  end

endmodule

// File: rtl/conway_sequencer.sv
// Conway array sequencer: serial seed load, one-shot array load, generation pacing.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  S_LOAD  | accepting seed beats into board_state_0
//  S_LATCH | cells_load pulse, board stable, generation cleared
//  S_HALT  | idle; seed beat reloads, run starts, step edge issues one gen
//  S_RUN   | free-running, one cells_ena per TICKS_PER_GEN cycles
module conway_sequencer
  import conway_pkg::*;
#(
  parameter int ROWS          = DEF_ROWS,
  parameter int COLS          = DEF_COLS,
  parameter int TICKS_PER_GEN = 4,
  parameter int GEN_W         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 seed_bit,
  input  logic                 seed_valid,
  output logic                 seed_ready,
  input  logic                 run,
  input  logic                 step,
  output logic [ROWS*COLS-1:0] board_state_0,
  output logic                 cells_load,
  output logic                 cells_ena,
  output logic [GEN_W-1:0]     generation,
  output logic                 running
);

  localparam int N     = ROWS * COLS;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  seq_state_t       state, next_state;
  logic [CNT_W-1:0] seed_count;
  logic             step_q;
  logic             step_edge;
  logic             beat;
  logic             tick;

  assign beat      = seed_valid && seed_ready;
  assign step_edge = step && !step_q;

  // Prescaler only runs while free-running with run still requested.
  tick_divider #(
    .TICKS (TICKS_PER_GEN)
  ) u_tick_divider (
    .clk   (clk),
    .rst   (rst),
    .clear (state != S_RUN),
    .en    ((state == S_RUN) && run),
    .tick  (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_LOAD;
    else      state <= next_state;
  end

  // Next-state logic; in HALT a seed beat outranks run, which outranks step.
  always_comb begin
    next_state = state;
    case (state)
      S_LOAD:  if (seed_valid && seed_count == LAST_IDX) next_state = S_LATCH;
      S_LATCH: next_state = S_HALT;
      S_HALT: begin
        if (seed_valid)  next_state = S_LOAD;
        else if (run)    next_state = S_RUN;
      end
      S_RUN:   if (!run) next_state = S_HALT;
      default: next_state = S_LOAD;
    endcase
  end

  // Combinational outputs decoded from state.
  always_comb begin
    seed_ready = (state == S_LOAD) || (state == S_HALT);
    running    = (state == S_RUN);
  end

  // Seed shift-in, load/enable pulses, generation counter and step history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seed_count    <= '0;
      board_state_0 <= '0;
      cells_load    <= 1'b0;
      cells_ena     <= 1'b0;
      generation    <= '0;
      step_q        <= 1'b0;
    end else begin
      cells_load <= 1'b0;
      cells_ena  <= 1'b0;
      step_q     <= step;
      case (state)
        S_LOAD: begin
          if (beat) begin
            board_state_0[seed_count] <= seed_bit;
            if (seed_count == LAST_IDX) begin
              seed_count <= '0;
              cells_load <= 1'b1;
              generation <= '0;
            end else begin
              seed_count <= seed_count + 1'b1;
            end
          end
        end
        S_HALT: begin
          if (beat) begin
            // A beat while halted starts a fresh load at cell 0.
            board_state_0[0] <= seed_bit;
            seed_count       <= CNT_W'(1);
          end else if (!run && step_edge) begin
            cells_ena  <= 1'b1;
            generation <= generation + 1'b1;
          end
        end
        S_RUN: begin
          if (tick) begin
            cells_ena  <= 1'b1;
            generation <= generation + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conway_sequencer.sv
// Scoreboard bench for conway_sequencer on a 3x3 board (dut0: 4 ticks/gen, dut1: 1 tick/gen).
module tb_conway_sequencer;

  typedef struct {
    bit         is_load;
    int         cyc;
    logic [8:0] board;
    logic [3:0] gen;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic seed_bit = 1'b0, seed_valid = 1'b0, run = 1'b0, step = 1'b0;
  bit   tgt = 1'b0;

  logic       sv0, sv1, run0, run1, step0, step1;
  logic       rdy0, rdy1, ld0, ld1, en0, en1, rn0, rn1;
  logic [8:0] brd0, brd1;
  logic [3:0] gen0, gen1;

  logic       rdy_t, rn_t;
  logic [8:0] brd_t;
  logic [3:0] gen_t;

  int   total = 0, bad = 0;
  int   cyc = 0;
  ev_t  q0[$], q1[$];
  logic [3:0] gen_m [2];
  logic [8:0] bmodel [2];

  assign sv0   = seed_valid & ~tgt;
  assign sv1   = seed_valid &  tgt;
  assign run0  = run  & ~tgt;
  assign run1  = run  &  tgt;
  assign step0 = step & ~tgt;
  assign step1 = step &  tgt;
  assign rdy_t = tgt ? rdy1 : rdy0;
  assign rn_t  = tgt ? rn1  : rn0;
  assign brd_t = tgt ? brd1 : brd0;
  assign gen_t = tgt ? gen1 : gen0;

  conway_sequencer #(.ROWS(3), .COLS(3), .TICKS_PER_GEN(4), .GEN_W(4)) dut0 (
    .clk(clk), .rst(rst), .seed_bit(seed_bit), .seed_valid(sv0), .seed_ready(rdy0),
    .run(run0), .step(step0), .board_state_0(brd0), .cells_load(ld0), .cells_ena(en0),
    .generation(gen0), .running(rn0));

  conway_sequencer #(.ROWS(3), .COLS(3), .TICKS_PER_GEN(1), .GEN_W(4)) dut1 (
    .clk(clk), .rst(rst), .seed_bit(seed_bit), .seed_valid(sv1), .seed_ready(rdy1),
    .run(run1), .step(step1), .board_state_0(brd1), .cells_load(ld1), .cells_ena(en1),
    .generation(gen1), .running(rn1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input bit ld, input int c, input logic [8:0] b, input logic [3:0] g);
    ev_t e;
    e.is_load = ld; e.cyc = c; e.board = b; e.gen = g;
    if (tgt) q1.push_back(e);
    else     q0.push_back(e);
  endtask

  // Monitor: pop the next expected event whenever a DUT pulses load or enable.
  task automatic mon(input int d, input logic ld, input logic en,
                     input logic [3:0] g, input logic [8:0] b);
    ev_t e;
    int  sz;
    if (ld || en) begin
      chk("load_ena_overlap", {31'd0, ld & en}, 32'd0);
      sz = (d == 0) ? q0.size() : q1.size();
      if (sz == 0) begin
        chk("unexpected_event", {30'd0, ld, en}, 32'd0);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk("evt_kind",  {31'd0, ld}, {31'd0, e.is_load});
        chk("evt_cycle", cyc, e.cyc);
        chk("evt_gen",   {28'd0, g}, {28'd0, e.gen});
        if (e.is_load) chk("load_board", {23'd0, b}, {23'd0, e.board});
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mon(0, ld0, en0, gen0, brd0);
      mon(1, ld1, en1, gen1, brd1);
    end
  end

  task automatic load_pattern(input logic [8:0] p, input int first);
    for (int i = first; i < 9; i++) begin
      @(negedge clk);
      chk("seed_ready_load", {31'd0, rdy_t}, 32'd1);
      seed_valid = 1'b1;
      seed_bit   = p[i];
      if (i == 8) begin
        gen_m[tgt]  = 4'd0;
        bmodel[tgt] = p;
        push_ev(1'b1, cyc + 1, p, 4'd0);
      end
    end
    @(negedge clk);
    seed_valid = 1'b0;
    chk("seed_ready_latch", {31'd0, rdy_t}, 32'd0);
  endtask

  // run held for h sampled edges: the first enters RUN, the remaining h-1 are counted.
  task automatic do_run(input int h, input bit spam);
    int t, a0;
    t = tgt ? 1 : 4;
    @(negedge clk);
    run = 1'b1;
    a0  = cyc;
    for (int m = 1; t * m <= h - 1; m++) begin
      gen_m[tgt] = gen_m[tgt] + 4'd1;
      push_ev(1'b0, a0 + 1 + t * m, 9'd0, gen_m[tgt]);
    end
    for (int i = 1; i <= h; i++) begin
      @(negedge clk);
      chk("running_in_run", {31'd0, rn_t}, 32'd1);
      chk("seed_ready_run", {31'd0, rdy_t}, 32'd0);
      if (spam) begin
        seed_valid = 1'($urandom);
        seed_bit   = 1'($urandom);
      end
    end
    run        = 1'b0;
    seed_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("running_after_run", {31'd0, rn_t}, 32'd0);
    chk("board_hold", {23'd0, brd_t}, {23'd0, bmodel[tgt]});
    chk("gen_after_run", {28'd0, gen_t}, {28'd0, gen_m[tgt]});
  endtask

  task automatic do_step(input logic [31:0] seq, input int len);
    bit prev;
    prev = 1'b0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      step = seq[i];
      if (seq[i] && !prev) begin
        gen_m[tgt] = gen_m[tgt] + 4'd1;
        push_ev(1'b0, cyc + 1, 9'd0, gen_m[tgt]);
      end
      prev = seq[i];
    end
    @(negedge clk);
    step = 1'b0;
    repeat (2) @(negedge clk);
    chk("gen_after_step", {28'd0, gen_t}, {28'd0, gen_m[tgt]});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_board"}, {23'd0, brd0}, 32'd0);
    chk({tag, "_load"},  {31'd0, ld0},  32'd0);
    chk({tag, "_ena"},   {31'd0, en0},  32'd0);
    chk({tag, "_gen"},   {28'd0, gen0}, 32'd0);
    chk({tag, "_run"},   {31'd0, rn0},  32'd0);
    chk({tag, "_ready"}, {31'd0, rdy0}, 32'd1);
  endtask

  initial begin
    logic [8:0] p;
    gen_m[0] = 4'd0; gen_m[1] = 4'd0;
    bmodel[0] = 9'd0; bmodel[1] = 9'd0;

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b1;

    // Blinker load, then free-run for 20 RUN cycles.
    load_pattern(9'h038, 0);
    @(negedge clk);
    chk("gen_after_load", {28'd0, gen0}, 32'd0);
    do_run(21, 1'b0);
    chk("gen_five", {28'd0, gen0}, 32'd5);

    // Step held high then three single pulses; seed traffic during RUN ignored.
    do_step(32'b0_1010_1011_1111_1111, 17);
    chk("gen_step_total", {28'd0, gen0}, 32'd9);
    do_run(9, 1'b1);

    // Seed beat, run and step together while halted: the beat wins.
    p = 9'h1A5;
    @(negedge clk);
    seed_valid = 1'b1; seed_bit = p[0]; run = 1'b1; step = 1'b1;
    @(negedge clk);
    seed_valid = 1'b0; run = 1'b0; step = 1'b0;
    chk("prio_running", {31'd0, rn0}, 32'd0);
    chk("prio_ready", {31'd0, rdy0}, 32'd1);
    load_pattern(p, 1);

    // Randomized rounds of load / run / step.
    for (int r = 0; r < 5; r++) begin
      load_pattern(9'($urandom), 0);
      do_run(int'($urandom_range(5, 30)), 1'($urandom));
      do_step($urandom, int'($urandom_range(4, 16)));
    end

    // Asynchronous reset after 5 of 9 beats, then a clean reload.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seed_valid = 1'b1; seed_bit = 1'b1;
    end
    @(negedge clk);
    seed_valid = 1'b0;
    #2 rst = 1'b0;
    #1 chk_reset_vals("midload_reset");
    gen_m[0] = 4'd0; bmodel[0] = 9'd0;
    @(negedge clk);
    #2 rst = 1'b1;
    load_pattern(9'h052, 0);

    // 17 generations wrap the 4-bit counter through 0 to 1.
    do_run(69, 1'b0);
    chk("gen_wrap", {28'd0, gen0}, 32'd1);

    // Single-tick build: enable on every RUN cycle.
    tgt = 1'b1;
    load_pattern(9'($urandom), 0);
    do_run(10, 1'b0);
    chk("tick1_gen", {28'd0, gen1}, 32'd9);

    repeat (5) @(negedge clk);
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
